// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter -- round-robin burst scheduler for the async_fifo write port.
//
// Shares one FIFO write port among P_NUM_REQ producers in the PROD_CLK domain.
// A grant lasts until the requester marks REQ_LAST, drops REQ, or reaches
// P_BURST_MAX beats. After every beat the write port stays quiet for
// P_WR_GAP cycles. No beat is issued while FIFO_FULL is high.
//
// Ports:
//   PROD_CLK     producer clock (only clock)
//   RST_n        asynchronous active-low reset
//   REQ          per-requester request level
//   REQ_DATA     per-requester data, slice i = [i*W +: W]
//   REQ_LAST     last beat of a burst, sampled with the beat
//   FIFO_FULL    FULL flag from the FIFO
//   GNT          one-hot registered grant
//   ACK          one-cycle pulse, beat accepted (coincident with W_EN)
//   W_EN         registered FIFO write enable
//   DATA_IN      registered FIFO write data
//   BUSY         high while not IDLE
//   WR_COUNT     (FIFO_WR_ARB_STATS_EN) per-requester saturating ACK count
//   STALL_COUNT  (FIFO_WR_ARB_STATS_EN) saturating count of FULL stall cycles
//
// Optional statistics counters are compiled in with `define FIFO_WR_ARB_STATS_EN.

module fifo_wr_arbiter #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_NUM_REQ    = 4,
  parameter int P_BURST_MAX  = 16,
  parameter int P_WR_GAP     = 2
) (
  input  logic                              PROD_CLK,
  input  logic                              RST_n,
  input  logic [P_NUM_REQ-1:0]              REQ,
  input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] REQ_DATA,
  input  logic [P_NUM_REQ-1:0]              REQ_LAST,
  input  logic                              FIFO_FULL,
  output logic [P_NUM_REQ-1:0]              GNT,
  output logic [P_NUM_REQ-1:0]              ACK,
  output logic                              W_EN,
  output logic [P_DATA_WIDTH-1:0]           DATA_IN,
  output logic                              BUSY
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [P_NUM_REQ*16-1:0]           WR_COUNT,
  output logic [15:0]                       STALL_COUNT
`endif
);

  localparam int             IW       = $clog2(P_NUM_REQ);
  localparam logic [2:0]     GAP_INIT = 3'(P_WR_GAP);
  localparam logic [7:0]     BMAX     = 8'(P_BURST_MAX);

  typedef enum logic [1:0] {IDLE, ARMED, GAP} state_t;

  state_t                    state, state_nx;
  logic [IW-1:0]             rr_ptr, rr_nx;
  logic [IW-1:0]             holder, holder_nx;
  logic [IW-1:0]             sel;
  logic                      found;
  logic [7:0]                burst_cnt, burst_nx;
  logic [2:0]                gap_cnt, gap_nx;
  logic                      last_q, last_nx;
  logic                      rel;
  logic [P_NUM_REQ-1:0]      gnt_nx, ack_nx;
  logic                      wen_nx;
  logic [P_DATA_WIDTH-1:0]   din_nx;
  int                        idx;

  // rr_ptr may not be a power of two, so wrap explicitly.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] p);
    return IW'((int'(p) + 1) % P_NUM_REQ);
  endfunction

  // Round-robin search: scan offsets high to low so the smallest offset
  // from rr_ptr is the one left in sel.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = P_NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % P_NUM_REQ;
      if (REQ[idx]) begin
        sel   = IW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    rr_nx     = rr_ptr;
    holder_nx = holder;
    burst_nx  = burst_cnt;
    gap_nx    = gap_cnt;
    last_nx   = last_q;
    gnt_nx    = GNT;
    ack_nx    = '0;
    wen_nx    = 1'b0;
    din_nx    = DATA_IN;
    rel       = 1'b0;

    case (state)
      IDLE: begin
        if (found) begin
          holder_nx   = sel;
          gnt_nx      = '0;
          gnt_nx[sel] = 1'b1;
          burst_nx    = '0;
          state_nx    = ARMED;
        end
      end

      ARMED: begin
        if (!REQ[holder]) begin
          rel = 1'b1;
        end else if (!FIFO_FULL) begin
          wen_nx         = 1'b1;
          din_nx         = REQ_DATA[holder*P_DATA_WIDTH +: P_DATA_WIDTH];
          ack_nx[holder] = 1'b1;
          burst_nx       = burst_cnt + 8'd1;
          last_nx        = REQ_LAST[holder];
          if (P_WR_GAP == 0) begin
            // No gap: keep streaming, but on a release pass through GAP for
            // one cycle so GNT still covers the ACK of the final beat.
            if (REQ_LAST[holder] || (burst_cnt + 8'd1) == BMAX) begin
              state_nx = GAP;
              gap_nx   = '0;
            end
          end else begin
            state_nx = GAP;
            gap_nx   = GAP_INIT;
          end
        end
      end

      GAP: begin
        // The exit edge is the one that takes gap_cnt to zero, giving one
        // beat every P_WR_GAP+1 cycles.
        gap_nx = (gap_cnt == 3'd0) ? 3'd0 : gap_cnt - 3'd1;
        if (gap_cnt <= 3'd1) begin
          if (last_q || burst_cnt == BMAX) rel = 1'b1;
          else                              state_nx = ARMED;
        end
      end

      default: state_nx = IDLE;
    endcase

    if (rel) begin
      gnt_nx   = '0;
      rr_nx    = wrap_inc(holder);
      state_nx = IDLE;
    end
  end

  always_ff @(posedge PROD_CLK or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge PROD_CLK or negedge RST_n) begin
    if (!RST_n) begin
      rr_ptr    <= '0;
      holder    <= '0;
      burst_cnt <= '0;
      gap_cnt   <= '0;
      last_q    <= 1'b0;
      GNT       <= '0;
      ACK       <= '0;
      W_EN      <= 1'b0;
      DATA_IN   <= '0;
      BUSY      <= 1'b0;
    end else begin
      rr_ptr    <= rr_nx;
      holder    <= holder_nx;
      burst_cnt <= burst_nx;
      gap_cnt   <= gap_nx;
      last_q    <= last_nx;
      GNT       <= gnt_nx;
      ACK       <= ack_nx;
      W_EN      <= wen_nx;
      DATA_IN   <= din_nx;
      BUSY      <= (state_nx != IDLE);
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [P_NUM_REQ-1:0][15:0] wr_cnt;
  logic [15:0]                stall_cnt;

  always_ff @(posedge PROD_CLK or negedge RST_n) begin
    if (!RST_n) begin
      wr_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < P_NUM_REQ; i++)
        if (ACK[i] && wr_cnt[i] != 16'hFFFF) wr_cnt[i] <= wr_cnt[i] + 16'd1;
      if (state == ARMED && REQ[holder] && FIFO_FULL && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign WR_COUNT    = wr_cnt;
  assign STALL_COUNT = stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter -- directed self-checking bench for fifo_wr_arbiter.
// Two instances share all inputs: dut_m with default parameters and dut_c
// with P_BURST_MAX=3 for the burst-cap scenario. A producer model advances
// each requester's data on ACK; expected beats sit in a scoreboard queue.

module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_last = '0;
  logic [N*W-1:0]  req_data = '0;
  logic            fifo_full = 1'b0;

  logic [N-1:0]    gnt_m, ack_m, gnt_c, ack_c;
  logic            wen_m, wen_c, busy_m, busy_c;
  logic [W-1:0]    din_m, din_c;

  logic            use_cap = 1'b0;
  logic [N-1:0]    o_gnt, o_ack;
  logic            o_wen, o_busy;
  logic [W-1:0]    o_din;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.P_DATA_WIDTH(W), .P_NUM_REQ(N), .P_BURST_MAX(16), .P_WR_GAP(2)) dut_m (
    .PROD_CLK(clk), .RST_n(rst_n), .REQ(req), .REQ_DATA(req_data), .REQ_LAST(req_last),
    .FIFO_FULL(fifo_full), .GNT(gnt_m), .ACK(ack_m), .W_EN(wen_m), .DATA_IN(din_m), .BUSY(busy_m));

  fifo_wr_arbiter #(.P_DATA_WIDTH(W), .P_NUM_REQ(N), .P_BURST_MAX(3), .P_WR_GAP(2)) dut_c (
    .PROD_CLK(clk), .RST_n(rst_n), .REQ(req), .REQ_DATA(req_data), .REQ_LAST(req_last),
    .FIFO_FULL(fifo_full), .GNT(gnt_c), .ACK(ack_c), .W_EN(wen_c), .DATA_IN(din_c), .BUSY(busy_c));

  always_comb begin
    o_gnt  = use_cap ? gnt_c  : gnt_m;
    o_ack  = use_cap ? ack_c  : ack_m;
    o_wen  = use_cap ? wen_c  : wen_m;
    o_din  = use_cap ? din_c  : din_m;
    o_busy = use_cap ? busy_c : busy_m;
  end

  typedef struct { int idx; logic [W-1:0] data; } beat_t;
  beat_t        sb[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] bdata[N];
  int           bnum[N];
  int           last_n[N];
  int           stop_after[N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_data[i*W +: W] = bdata[i];
      req_last[i] = (last_n[i] == 0) ? 1'b0 : (((bnum[i] + 1) % last_n[i]) == 0);
    end
  endtask

  // One clock: sample #1 after the edge, check invariants and beats, then
  // let the producer model react to ACK.
  task automatic tick();
    logic  full_e;
    beat_t b;
    full_e = fifo_full;
    @(posedge clk);
    #1;
    chk("gnt_onehot", 32'(o_gnt & (o_gnt - 4'd1)), 32'd0);
    chk("ack_in_gnt", 32'(o_ack & ~o_gnt), 32'd0);
    chk("wen_ack", 32'(o_wen), 32'(|o_ack));
    if (o_wen) begin
      chk("wen_vs_full", 32'(full_e), 32'd0);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL unexpected_beat: observed data %0h expected no beat", o_din);
      end else begin
        b = sb.pop_front();
        chk("beat_data", 32'(o_din), 32'(b.data));
        chk("beat_ack", 32'(o_ack), 32'(1 << b.idx));
      end
    end
    for (int i = 0; i < N; i++) begin
      if (o_ack[i]) begin
        bnum[i]++;
        bdata[i] = bdata[i] + 8'd1;
        if (stop_after[i] != 0 && bnum[i] == stop_after[i]) req[i] = 1'b0;
      end
    end
    drive();
  endtask

  task automatic setup_req(input int i, input logic [W-1:0] d, input int ln, input int sa);
    bdata[i]      = d;
    bnum[i]       = 0;
    last_n[i]     = ln;
    stop_after[i] = sa;
    req[i]        = 1'b1;
    drive();
  endtask

  task automatic push(input int i, input logic [W-1:0] d);
    beat_t b;
    b.idx  = i;
    b.data = d;
    sb.push_back(b);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    fifo_full = 1'b0;
    sb.delete();
    for (int i = 0; i < N; i++) begin
      bdata[i] = '0; bnum[i] = 0; last_n[i] = 0; stop_after[i] = 0;
    end
    drive();
    #2;
    chk("rst_outputs", 32'({o_gnt, o_ack, o_wen, o_din, o_busy}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int seen;
    seen = 0;
    for (int k = 0; k < budget && seen < n; k++) begin
      tick();
      if (o_wen) seen++;
    end
    chk("wait_beats", 32'(seen), 32'(n));
  endtask

  initial begin
    #1;

    // Single requester, four beats, LAST on the fourth.
    do_reset();
    for (int d = 0; d < 4; d++) push(1, 8'(8'hA0 + d));
    setup_req(1, 8'hA0, 4, 4);
    for (int k = 1; k <= 13; k++) begin
      tick();
      chk("t1_wen", 32'(o_wen), 32'(k == 2 || k == 5 || k == 8 || k == 11));
      if (k == 1 || k == 12) chk("t1_gnt_held", 32'(o_gnt), 32'h2);
    end
    chk("t1_gnt_rel", 32'(o_gnt), 32'd0);
    chk("t1_busy", 32'(o_busy), 32'd0);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // Fairness: all request, LAST every beat -> 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < N; i++) setup_req(i, 8'(16 * (i + 1)), 1, 0);
    push(0, 8'h10); push(1, 8'h20); push(2, 8'h30); push(3, 8'h40); push(0, 8'h11);
    wait_beats(5, 60);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Burst cap of 3 on the capped instance, only requester 2.
    do_reset();
    use_cap = 1'b1;
    setup_req(2, 8'h30, 0, 0);
    push(2, 8'h30); push(2, 8'h31); push(2, 8'h32);
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk("t3_wen", 32'(o_wen), 32'(k == 2 || k == 5 || k == 8));
      if (k == 9)  chk("t3_gnt_held", 32'(o_gnt), 32'h4);
      if (k == 10) begin
        chk("t3_gnt_rel", 32'(o_gnt), 32'd0);
        chk("t3_busy_idle", 32'(o_busy), 32'd0);
      end
      if (k == 11) chk("t3_regrant", 32'(o_gnt), 32'h4);
    end
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);
    use_cap = 1'b0;

    // FULL stall for 10 cycles while ARMED.
    do_reset();
    fifo_full = 1'b1;
    setup_req(0, 8'h50, 1, 1);
    push(0, 8'h50);
    tick();
    chk("t4_gnt", 32'(o_gnt), 32'h1);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t4_stall_wen", 32'(o_wen), 32'd0);
      chk("t4_stall_gnt", 32'(o_gnt), 32'h1);
    end
    fifo_full = 1'b0;
    tick();
    chk("t4_first_beat", 32'(o_wen), 32'd1);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);

    // Requester 0 aborts after 2 beats; requester 3 waiting.
    do_reset();
    setup_req(0, 8'h60, 0, 2);
    setup_req(3, 8'h70, 1, 1);
    push(0, 8'h60); push(0, 8'h61); push(3, 8'h70);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1 || k == 7) chk("t5_gnt0", 32'(o_gnt), 32'h1);
      if (k == 8) begin
        chk("t5_gnt_rel", 32'(o_gnt), 32'd0);
        chk("t5_no_beat", 32'(o_wen), 32'd0);
      end
      if (k == 9)  chk("t5_gnt3", 32'(o_gnt), 32'h8);
      if (k == 10) chk("t5_beat3", 32'(o_wen), 32'd1);
    end
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);

    // Reset asserted during a W_EN cycle.
    do_reset();
    setup_req(0, 8'h80, 0, 0);
    push(0, 8'h80);
    tick();
    tick();
    chk("t6_wen", 32'(o_wen), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_rst", 32'({o_gnt, o_ack, o_wen, o_din, o_busy}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("t6_regrant", 32'(o_gnt), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port scheduler for the producer side of async_fifo.
- Shares the single FIFO write port among P_NUM_REQ producers and grants in bursts.
- Enforces the FIFO's minimum write spacing and stalls on FULL.
- Sits in the PROD_CLK domain, directly in front of the FIFO W_EN/DATA_IN pins.

Parameters:
- P_DATA_WIDTH, 8: FIFO data width.
- P_NUM_REQ, 4: number of requesters (2..8).
- P_BURST_MAX, 16: maximum beats per grant before forced rotation (1..255).
- P_WR_GAP, 2: idle PROD_CLK cycles inserted after every W_EN pulse (0..7).

Ports:
- PROD_CLK  in  1  producer clock; the only clock.
- RST_n  in  1  asynchronous, active-low reset.
- REQ  in  P_NUM_REQ  per-requester request level.
- REQ_DATA  in  P_NUM_REQ*P_DATA_WIDTH  per-requester data; slice i = bits [i*W +: W].
- REQ_LAST  in  P_NUM_REQ  marks the final beat of a burst; sampled with the beat.
- FIFO_FULL  in  1  FULL from the FIFO.
- GNT  out  P_NUM_REQ  one-hot registered grant.
- ACK  out  P_NUM_REQ  one-cycle pulse: beat accepted this cycle.
- W_EN  out  1  registered FIFO write enable.
- DATA_IN  out  P_DATA_WIDTH  registered FIFO write data.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset is asynchronous, active-low. During reset: GNT=0, ACK=0, W_EN=0, DATA_IN=0, BUSY=0, state=IDLE, rr_ptr=0, burst_cnt=0, gap_cnt=0.
- Reset asserted mid-burst forces the same values immediately. An in-flight beat is dropped with no ACK.
- All outputs are registered.
- IDLE:
  - If any REQ is high, select the first set bit searching from rr_ptr upward, wrapping modulo P_NUM_REQ.
  - Next cycle: GNT[sel]=1, state ARMED, burst_cnt=0.
- ARMED:
  - REQ[holder]=0: drop GNT, set rr_ptr=holder+1 mod N, go to IDLE (no beat).
  - REQ[holder]=1 and FIFO_FULL=1: hold GNT, W_EN=0 (stall; no timeout).
  - REQ[holder]=1 and FIFO_FULL=0: next cycle W_EN=1, DATA_IN=REQ_DATA[holder], ACK[holder]=1, burst_cnt+1, latch REQ_LAST[holder] into last_q.
  - After a beat: go to GAP with gap_cnt=P_WR_GAP. If P_WR_GAP=0, evaluate GAP exit immediately.
- GAP:
  - W_EN=0 and ACK=0; GNT is held.
  - gap_cnt decrements each cycle.
  - At 0: if last_q=1 or burst_cnt==P_BURST_MAX, release (GNT=0, rr_ptr=holder+1 mod N, IDLE). Otherwise return to ARMED.
- Latency:
  - REQ rise in IDLE -> GNT after 1 cycle -> first W_EN/ACK after 1 more cycle, if not FULL.
  - Steady-state beat rate: one per P_WR_GAP+1 cycles.
- Release cost: one IDLE cycle between grants. Simultaneous requests are resolved strictly by rr_ptr order, never by index priority.
- FIFO_FULL rising during GAP has no effect until ARMED.
- FIFO_FULL is sampled in the same cycle the beat is issued. No W_EN is ever issued while FIFO_FULL=1.
- burst_cnt is 8 bits; compare on equality only.
- rr_ptr is $clog2(P_NUM_REQ) bits; wrap uses explicit modulo for non-power-of-2 N.
- Invariants:
  - GNT has at most one bit set.
  - ACK is a subset of GNT.
  - ACK and W_EN are coincident.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- Defined:
  - Adds output WR_COUNT (P_NUM_REQ*16): per-requester 16-bit saturating count of ACKs.
  - Adds output STALL_COUNT (16): saturating count of ARMED cycles with FIFO_FULL=1 and REQ[holder]=1.
  - Both counters clear on reset only.
- Not defined: neither port nor counter exists; the core behaviour is identical.

Test Plan:
- Single requester, N=4, gap=2: REQ[1]=1 with data 0xA0..0xA3, LAST on the 4th beat -> GNT=0010, four W_EN pulses spaced 3 cycles apart with DATA_IN 0xA0..0xA3, then GNT=0 and BUSY=0.
- Fairness: REQ=1111 held, LAST on every beat -> grant order 0,1,2,3,0; exactly one beat per grant.
- Burst cap, P_BURST_MAX=3: REQ[2] held, never LAST -> GNT drops after 3 ACKs, then re-granted to requester 2 after one IDLE cycle (only requester).
- FULL stall: FIFO_FULL=1 for 10 cycles while ARMED -> W_EN=0 throughout, GNT held; first beat W_EN 1 cycle after FULL falls.
- Requester abort: REQ[0] drops in ARMED after 2 beats, REQ[3]=1 -> release; GNT=1000 after the IDLE cycle, rr_ptr=1 and search from 1 selects requester 3.
- Reset mid-burst: RST_n low during a W_EN cycle -> all outputs 0 asynchronously; after release with REQ=0001 -> GNT=0001 within 1 cycle.
